pipe_skid_reg: RTL and testbench

Parametrised pipeline stage register with a 2-entry skid buffer and valid/ready handshakes on both sides. On the input side it has an N-way forwarding select and an extension/shift unit. Together these generalise the 32-bit/5-bit/3-way muxes, the sign extender and the jump shifter into one registered stage. It sits between CPU pipeline stages (e.g. ID->EX) and supports back-pressure (stall) and flush without losing or duplicating data.

---
 rtl/pipe_skid_reg.sv | 124 ++++++++++++
 tb/tb_pipe_skid_reg.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Registered pipeline stage with a 2-entry skid buffer, forwarding select and
// an extend/shift transform applied to the word at accept time.
module pipe_skid_reg #(
   parameter int                 WIDTH    = 32,
   parameter int                 NUM_SRC  = 3,
   parameter int                 SEL_W    = 2,
   parameter int                 EXT_IN_W = 16,
   parameter logic [WIDTH-1:0]   BUBBLE   = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [NUM_SRC*WIDTH-1:0]   src_data,
   input  logic [SEL_W-1:0]           src_sel,
   input  logic [1:0]                 ext_mode,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [1:0]                 occupancy,
   output logic                       sel_err
);

   // Occupancy doubles as the FSM state and is exported on the occupancy port.
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   logic [1:0]       r_state;
   logic             r_in_ready;
   logic             r_sel_err;
   logic [WIDTH-1:0] r_head;
   logic [WIDTH-1:0] r_skid;

   logic [WIDTH-1:0] w_sel;
   logic             w_sel_oob;
   logic [WIDTH-1:0] w_word;
   logic             w_accept;
   logic             w_drain;
   logic [1:0]       w_state_nxt;
   logic [WIDTH-1:0] w_head_nxt;
   logic [WIDTH-1:0] w_skid_nxt;

   // Out-of-range selects fall back to source 0.
   always_comb begin
      w_sel = src_data[0 +: WIDTH];
      for (int k = 1; k < NUM_SRC; k++) begin
         if (src_sel == SEL_W'(k)) w_sel = src_data[k*WIDTH +: WIDTH];
      end
   end

   assign w_sel_oob = (32'(src_sel) >= NUM_SRC);

   always_comb begin
      w_word = w_sel;
      case (ext_mode)
         2'b01:   w_word = {{(WIDTH-EXT_IN_W){w_sel[EXT_IN_W-1]}}, w_sel[EXT_IN_W-1:0]};
         2'b10:   w_word = {{(WIDTH-EXT_IN_W){1'b0}}, w_sel[EXT_IN_W-1:0]};
         2'b11:   w_word = {w_sel[WIDTH-3:0], 2'b00};
         default: w_word = w_sel;
      endcase
   end

   // A word moves on an edge where valid and ready are both high; in_ready is
   // a flop so out_ready never reaches it combinationally.
   assign w_accept = in_valid & r_in_ready;
   assign w_drain  = out_valid & out_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_head_nxt  = r_head;
      w_skid_nxt  = r_skid;
      case (r_state)
         ST_EMPTY: begin
            if (w_accept) begin
               w_state_nxt = ST_ONE;
               w_head_nxt  = w_word;
            end
         end
         ST_ONE: begin
            if (w_accept && w_drain) begin
               w_head_nxt = w_word;
            end else if (w_accept) begin
               w_state_nxt = ST_FULL;
               w_skid_nxt  = w_word;
            end else if (w_drain) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (w_drain) begin
               w_state_nxt = ST_ONE;
               w_head_nxt  = r_skid;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
      if (flush) w_state_nxt = ST_EMPTY;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_EMPTY;
         r_in_ready <= 1'b1;
         r_sel_err  <= 1'b0;
         r_head     <= BUBBLE;
         r_skid     <= BUBBLE;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= (w_state_nxt != ST_FULL);
         r_head     <= w_head_nxt;
         r_skid     <= w_skid_nxt;
         if (w_accept && w_sel_oob) r_sel_err <= 1'b1;
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = (r_state != ST_EMPTY);
   assign out_data  = out_valid ? r_head : BUBBLE;
   assign occupancy = r_state;
   assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: one task per scenario, inline checks.
module tb_pipe_skid_reg;

   localparam int WIDTH   = 32;
   localparam int NUM_SRC = 3;
   localparam int SEL_W   = 2;

   logic                     clk = 1'b0;
   logic                     reset;
   logic                     in_valid;
   logic                     in_ready;
   logic [NUM_SRC*WIDTH-1:0] src_data;
   logic [SEL_W-1:0]         src_sel;
   logic [1:0]               ext_mode;
   logic                     flush;
   logic                     out_valid;
   logic                     out_ready;
   logic [WIDTH-1:0]         out_data;
   logic [1:0]               occupancy;
   logic                     sel_err;

   int total = 0;
   int bad   = 0;
   logic [WIDTH-1:0] exp_q[$];

   pipe_skid_reg #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .EXT_IN_W(16), .BUBBLE('0)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .src_data(src_data), .src_sel(src_sel), .ext_mode(ext_mode), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .occupancy(occupancy), .sel_err(sel_err)
   );

   always #5 clk = ~clk;

   // Advance one edge; inputs change and outputs are sampled 1 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input logic [WIDTH-1:0] s0, input logic [WIDTH-1:0] s1,
                          input logic [WIDTH-1:0] s2);
      src_data = {s2, s1, s0};
   endtask

   task automatic push(input logic [WIDTH-1:0] d);
      set_src(d, 32'h0, 32'h0);
      src_sel  = 2'd0;
      ext_mode = 2'b00;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
      total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_data: got %h exp 00000000", out_data); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
      total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL reset_occ: got %0d exp 0", occupancy); end
      total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL reset_sel_err: got %b exp 0", sel_err); end
      reset = 1'b0;
   endtask

   task automatic test_pass_through();
      out_ready = 1'b1;
      set_src(32'hDEAD_0000, 32'h0000_1234, 32'hBEEF_0000);
      src_sel  = 2'd1;
      ext_mode = 2'b00;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1 || out_data !== 32'h0000_1234) begin
         bad++; $display("FAIL pass_data: got v=%b %h exp v=1 00001234", out_valid, out_data); end
      total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL pass_occ1: got %0d exp 1", occupancy); end
      tick();
      total++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin
         bad++; $display("FAIL pass_one_cycle: got v=%b %h exp v=0 00000000", out_valid, out_data); end
      total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL pass_occ0: got %0d exp 0", occupancy); end
   endtask

   task automatic test_extend();
      logic [WIDTH-1:0] vin [4];
      logic [1:0]       vmode [4];
      logic [WIDTH-1:0] vexp [4];
      vin[0] = 32'h0000_8001; vmode[0] = 2'b01; vexp[0] = 32'hFFFF_8001;
      vin[1] = 32'h0000_8001; vmode[1] = 2'b10; vexp[1] = 32'h0000_8001;
      vin[2] = 32'h4000_0003; vmode[2] = 2'b11; vexp[2] = 32'h0000_000C;
      vin[3] = 32'hFFFF_7FFF; vmode[3] = 2'b01; vexp[3] = 32'h0000_7FFF;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         set_src(vin[i], 32'h1111_1111, 32'h2222_2222);
         src_sel  = 2'd0;
         ext_mode = vmode[i];
         in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         set_src(32'h0, 32'h0, 32'h0);
         total++; if (out_valid !== 1'b1 || out_data !== vexp[i]) begin
            bad++; $display("FAIL ext_mode%0d_%0d: got v=%b %h exp v=1 %h", vmode[i], i, out_valid, out_data, vexp[i]); end
         tick();
      end
      ext_mode = 2'b00;
   endtask

   task automatic test_back_to_back();
      logic will_accept;
      out_ready = 1'b0;
      push(32'h11);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after_a: got %b exp 1", in_ready); end
      push(32'h22);
      total++; if (in_ready !== 1'b0 || occupancy !== 2'd2) begin
         bad++; $display("FAIL bp_full: got rdy=%b occ=%0d exp rdy=0 occ=2", in_ready, occupancy); end
      set_src(32'h33, 32'h0, 32'h0);
      in_valid = 1'b1;
      tick();
      total++; if (occupancy !== 2'd2 || out_data !== 32'h11) begin
         bad++; $display("FAIL bp_hold: got occ=%0d %h exp occ=2 00000011", occupancy, out_data); end
      exp_q = {32'h11, 32'h22, 32'h33};
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         total++; if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
            bad++; $display("FAIL bp_order_%0d: got v=%b %h exp v=1 %h", i, out_valid, out_data, exp_q[0]); end
         void'(exp_q.pop_front());
         will_accept = in_valid & in_ready;
         tick();
         if (will_accept) in_valid = 1'b0;
      end
      total++; if (out_valid !== 1'b0 || in_valid !== 1'b0) begin
         bad++; $display("FAIL bp_drained: got v=%b in_valid=%b exp 0 0", out_valid, in_valid); end
      in_valid = 1'b0;
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      push(32'h01);
      push(32'h02);
      set_src(32'h55, 32'h0, 32'h0);
      in_valid = 1'b1;
      flush    = 1'b1;
      tick();
      in_valid = 1'b0;
      flush    = 1'b0;
      total++; if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1 || occupancy !== 2'd0) begin
         bad++; $display("FAIL flush_full: got v=%b %h rdy=%b occ=%0d exp v=0 00000000 rdy=1 occ=0",
                         out_valid, out_data, in_ready, occupancy); end
      // occupancy 1, flush races an accepted word
      push(32'h03);
      set_src(32'h66, 32'h0, 32'h0);
      in_valid = 1'b1;
      flush    = 1'b1;
      tick();
      in_valid = 1'b0;
      flush    = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         total++; if (out_valid !== 1'b0) begin
            bad++; $display("FAIL flush_discard_%0d: got v=%b %h exp v=0", i, out_valid, out_data); end
         tick();
      end
   endtask

   task automatic test_sel_err();
      out_ready = 1'b1;
      set_src(32'hAAAA_AAAA, 32'h1111_1111, 32'h2222_2222);
      src_sel  = 2'd3;
      ext_mode = 2'b00;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      src_sel  = 2'd0;
      total++; if (out_data !== 32'hAAAA_AAAA) begin bad++; $display("FAIL selerr_data: got %h exp aaaaaaaa", out_data); end
      total++; if (sel_err !== 1'b1) begin bad++; $display("FAIL selerr_set: got %b exp 1", sel_err); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      total++; if (sel_err !== 1'b1) begin bad++; $display("FAIL selerr_flush: got %b exp 1", sel_err); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL selerr_reset: got %b exp 0", sel_err); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      push(32'h0A);
      push(32'h0B);
      set_src(32'h99, 32'h0, 32'h0);
      src_sel  = 2'd3;
      reset    = 1'b1;
      flush    = 1'b1;
      in_valid = 1'b1;
      tick();
      reset    = 1'b0;
      flush    = 1'b0;
      in_valid = 1'b0;
      src_sel  = 2'd0;
      total++; if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1 ||
                   occupancy !== 2'd0 || sel_err !== 1'b0) begin
         bad++; $display("FAIL rstmid_state: got v=%b %h rdy=%b occ=%0d err=%b exp 0 00000000 1 0 0",
                         out_valid, out_data, in_ready, occupancy, sel_err); end
      out_ready = 1'b1;
      push(32'h77);
      total++; if (out_valid !== 1'b1 || out_data !== 32'h77) begin
         bad++; $display("FAIL rstmid_push: got v=%b %h exp v=1 00000077", out_valid, out_data); end
      tick();
      total++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
         bad++; $display("FAIL rstmid_drain: got v=%b occ=%0d exp 0 0", out_valid, occupancy); end
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      src_data  = '0;
      src_sel   = '0;
      ext_mode  = 2'b00;
      flush     = 1'b0;
      out_ready = 1'b0;
      #2;
      test_reset();
      test_pass_through();
      test_extend();
      test_back_to_back();
      test_flush();
      test_sel_err();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
